conv_mac_stage: RTL
===================

# conv_mac_stage

Pipelined signed multiply-accumulate stage of the 2D convolution accelerator. Consumes a stream of packed {weight, pixel} pairs over AXI-Stream and accumulates every M consecutive products into one convolution result. Emits each result over AXI-Stream directly into the output FIFO, honouring its backpressure. Sits between the window/weight sequencer upstream and the output FIFO downstream.

## Interface
- INW, 8: width of pixel and of weight, both two's-complement signed.
- OUTW, 24: result width; must match the output FIFO data width.
- M, 9: products per result (K*K taps); M >= 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- IN_AXIS_TDATA  in  2*INW  [2*INW-1:INW] = weight, [INW-1:0] = pixel.
- IN_AXIS_TVALID  in  1  upstream has a pair.
- IN_AXIS_TREADY  out  1  stage accepts a pair this cycle.
- OUT_AXIS_TDATA  out  OUTW  convolution result, signed.
- OUT_AXIS_TVALID  out  1  result held valid.
- OUT_AXIS_TREADY  in  1  output FIFO accepts.

## Operation
- Global advance enable: en = !OUT_AXIS_TVALID || OUT_AXIS_TREADY. IN_AXIS_TREADY = en (combinational, no dependency on IN_AXIS_TVALID).
- Input accept: IN_AXIS_TVALID && en.
- Tap counter cnt (0..M-1): increments on each accept; wraps from M-1 to 0. Accept with cnt == M-1 is the last tap.
- Stage 1 (product register), on en: p <= sign-extended pixel * weight, full 2*INW-bit product, sign-extended to OUTW; p_valid <= accept; p_last <= last tap.
- Stage 2 (accumulator), on en && p_valid:
  - not p_last: acc <= acc + p.
  - p_last: result register <= acc + p; acc <= 0; OUT_AXIS_TVALID <= 1.
- On en with no (p_valid && p_last): OUT_AXIS_TVALID <= 0 (previous result consumed or none present).
- When en = 0 (result held, FIFO not ready): p, p_valid, p_last, acc, cnt, result all hold.
- Arithmetic: all sums modulo 2^OUTW, two's-complement wrap; no saturation.
- OUT_AXIS_TDATA is stable while OUT_AXIS_TVALID && !OUT_AXIS_TREADY.

## Timing
- Reset values: OUT_AXIS_TVALID = 0, OUT_AXIS_TDATA = 0, acc = 0, cnt = 0, p = 0, p_valid = 0, p_last = 0. IN_AXIS_TREADY = 1 the cycle after reset is released.
- Latency: last tap accepted at edge n -> OUT_AXIS_TVALID = 1 after edge n+1.
- Throughput: one pair per cycle while downstream ready; no bubbles between results.
- Back-to-back: result emitted at edge n+1 and next group's first product accumulated in the same edge from acc = 0.
- Backpressure: result valid and OUT_AXIS_TREADY = 0 -> IN_AXIS_TREADY = 0 same cycle; no pair lost or duplicated.
- Simultaneous handshake out + new last tap in stage 2: result register reloads, OUT_AXIS_TVALID stays 1.
- Reset mid-group: partial accumulation and in-flight product discarded; next accepted pair is tap 0.
- Gaps on IN_AXIS_TVALID: p_valid = 0, acc holds, cnt holds.

## Configuration
- CONV_MAC_RELU_EN defined: at the p_last load, result register <= 0 if (acc + p) is negative (MSB set), else acc + p.
- Undefined: result register <= acc + p unchanged, negative results emitted as two's-complement.

## Test plan
- Nine pairs weight 1, pixel 1..9, OUT_AXIS_TREADY = 1 -> one result 24'd45, OUT_AXIS_TVALID high 2 cycles after last accept.
- Nine pairs weight 2, pixel -3 -> 24'hFFFFCA without CONV_MAC_RELU_EN; 24'h000000 with it.
- Nine pairs weight -128, pixel -128 -> 24'h024000 (147456), no overflow.
- Result valid, hold OUT_AXIS_TREADY = 0 for 5 cycles while upstream drives pairs -> IN_AXIS_TREADY = 0, OUT_AXIS_TDATA stable, next group result correct after release.
- 36 continuous pairs (4 groups, pixel = index 0..35, weight 1), OUT_AXIS_TREADY = 1 -> results 36, 117, 198, 279 on consecutive group boundaries, zero input stalls.
- Assert reset after 4 taps, then nine pairs weight 1 pixel 1 -> result 24'd9 (partial sum discarded).

Source files
------------

// File: rtl/conv_mac_stage_if.sv
// AXI-Stream style channel for conv_mac_stage: TDATA/TVALID/TREADY of width W.
// master drives data/valid, slave drives ready.
interface conv_mac_stage_if #(
   parameter int W = 16
);
   logic [W-1:0] TDATA;
   logic         TVALID;
   logic         TREADY;

   modport master (output TDATA, output TVALID, input TREADY);
   modport slave  (input TDATA, input TVALID, output TREADY);
endinterface

// File: rtl/conv_mac_stage.sv
// Pipelined signed MAC stage: accumulates every M {weight, pixel} products into one result.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to zero.
module conv_mac_stage #(
   parameter int INW  = 8,
   parameter int OUTW = 24,
   parameter int M    = 9
) (
   input  logic             clk,
   input  logic             reset,
   conv_mac_stage_if.slave  in_axis,
   conv_mac_stage_if.master out_axis
);
   localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(M - 1);

   logic                   en;
   logic                   accept;
   logic                   last_tap;
   logic signed [INW-1:0]  weight;
   logic signed [INW-1:0]  pixel;
   logic signed [2*INW-1:0] prod;
   logic [OUTW-1:0]        sum;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUTW-1:0]  p_q, p_d;
   logic [OUTW-1:0]  acc_q, acc_d;
   logic [OUTW-1:0]  res_q, res_d;
   logic             p_valid_q, p_valid_d;
   logic             p_last_q, p_last_d;
   logic             out_valid_q, out_valid_d;

   // The whole pipeline freezes only while a result is held against a stalled FIFO.
   assign en             = !out_valid_q || out_axis.TREADY;
   assign in_axis.TREADY = en;
   assign accept         = in_axis.TVALID && en;
   assign last_tap       = (cnt_q == LAST_CNT);

   assign weight = in_axis.TDATA[2*INW-1:INW];
   assign pixel  = in_axis.TDATA[INW-1:0];
   assign prod   = weight * pixel;
   assign sum    = acc_q + p_q;

   assign out_axis.TDATA  = res_q;
   assign out_axis.TVALID = out_valid_q;

   always_comb begin
      cnt_d       = cnt_q;
      p_d         = p_q;
      p_valid_d   = p_valid_q;
      p_last_d    = p_last_q;
      acc_d       = acc_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;
      if (en) begin
         if (accept) begin
            cnt_d = last_tap ? '0 : cnt_q + 1'b1;
         end
         p_d         = OUTW'(prod);
         p_valid_d   = accept;
         p_last_d    = accept && last_tap;
         out_valid_d = p_valid_q && p_last_q;
         if (p_valid_q) begin
            if (p_last_q) begin
`ifdef CONV_MAC_RELU_EN
               res_d = sum[OUTW-1] ? '0 : sum;
`else
               res_d = sum;
`endif
               acc_d = '0;
            end else begin
               acc_d = sum;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         p_q         <= '0;
         p_valid_q   <= 1'b0;
         p_last_q    <= 1'b0;
         acc_q       <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         p_valid_q   <= p_valid_d;
         p_last_q    <= p_last_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule
